// File: rtl/apu_i2s_receiver.sv
// ============================================================================
// apu_i2s_receiver : I2S capture into MCLK-domain stereo frames (valid/ready)
// Revision 1.0
// ============================================================================
`default_nettype none

module apu_i2s_receiver #(
  parameter int SAMPLE_WIDTH = 24,
  parameter int SLOT_WIDTH   = 32,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                    mclk_i,
  input  logic                    reset_n_i,
  input  logic                    lrclk_i,
  input  logic                    sclk_i,
  input  logic                    din_i,
  output logic [SAMPLE_WIDTH-1:0] left_sample_o,
  output logic [SAMPLE_WIDTH-1:0] right_sample_o,
  output logic                    sample_valid_o,
  input  logic                    sample_ready_i,
  output logic                    overrun_o,
  output logic                    framing_error_o,
  input  logic                    err_clear_i
);

  localparam int CNT_W = (SAMPLE_WIDTH > 1) ? $clog2(SAMPLE_WIDTH) : 1;

  generate
    if (SLOT_WIDTH < SAMPLE_WIDTH + 1 || SYNC_STAGES < 2) begin : g_param_check
      $error("apu_i2s_receiver: invalid SLOT_WIDTH or SYNC_STAGES");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_WAIT_LEFT = 2'd0,
    S_DELAY     = 2'd1,
    S_SHIFT     = 2'd2,
    S_PAD       = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0]  lr_sync_q, sclk_sync_q, din_sync_q;
  logic                    lr_prev_q, sclk_prev_q;
  state_t                  state_q, state_d;
  logic                    chan_q, chan_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [SAMPLE_WIDTH-2:0] shift_q, shift_d;
  logic [SAMPLE_WIDTH-1:0] stage_q, stage_d;
  logic [SAMPLE_WIDTH-1:0] left_q, left_d, right_q, right_d;
  logic                    valid_q, valid_d;
  logic                    ovr_q, ovr_d, fe_q, fe_d;

  logic                    w_lr_s, w_sclk_s, w_din_s;
  logic                    w_lr_fall, w_lr_rise, w_sclk_rise, w_last;
  logic [SAMPLE_WIDTH-1:0] w_word;
  state_t                  w_start;
  logic                    frame_done, fe_set, ovr_set;

  always_ff @(posedge mclk_i) begin
    if (!reset_n_i) begin
      lr_sync_q   <= '0;
      sclk_sync_q <= '0;
      din_sync_q  <= '0;
      lr_prev_q   <= 1'b0;
      sclk_prev_q <= 1'b0;
    end else begin
      lr_sync_q   <= {lr_sync_q[SYNC_STAGES-2:0], lrclk_i};
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
      din_sync_q  <= {din_sync_q[SYNC_STAGES-2:0], din_i};
      lr_prev_q   <= lr_sync_q[SYNC_STAGES-1];
      sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
    end
  end

  assign w_lr_s      = lr_sync_q[SYNC_STAGES-1];
  assign w_sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign w_din_s     = din_sync_q[SYNC_STAGES-1];
  assign w_lr_fall   = lr_prev_q & ~w_lr_s;
  assign w_lr_rise   = ~lr_prev_q & w_lr_s;
  assign w_sclk_rise = ~sclk_prev_q & w_sclk_s;
  assign w_word      = {shift_q, w_din_s};
  assign w_last      = (cnt_q == CNT_W'(SAMPLE_WIDTH - 1));
  // An SCLK edge coinciding with the slot-start edge is the delay bit itself.
  assign w_start     = w_sclk_rise ? S_SHIFT : S_DELAY;

  always_comb begin
    state_d    = state_q;
    chan_d     = chan_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    stage_d    = stage_q;
    frame_done = 1'b0;
    fe_set     = 1'b0;
    case (state_q)
      S_WAIT_LEFT: begin
        if (w_lr_fall) begin
          state_d = w_start;
          chan_d  = 1'b0;
          cnt_d   = '0;
        end
      end
      S_DELAY, S_SHIFT: begin
        if (w_lr_fall) begin
          fe_set  = 1'b1;
          state_d = w_start;
          chan_d  = 1'b0;
          cnt_d   = '0;
        end else if (w_lr_rise) begin
          fe_set  = 1'b1;
          state_d = S_WAIT_LEFT;
          chan_d  = 1'b0;
          cnt_d   = '0;
          stage_d = '0;
        end else if (w_sclk_rise) begin
          if (state_q == S_DELAY) begin
            state_d = S_SHIFT;
          end else begin
            shift_d = w_word[SAMPLE_WIDTH-2:0];
            cnt_d   = cnt_q + 1'b1;
            if (w_last) begin
              cnt_d   = '0;
              state_d = S_PAD;
              if (!chan_q) stage_d = w_word;
              else         frame_done = 1'b1;
            end
          end
        end
      end
      S_PAD: begin
        if (w_lr_rise && !chan_q) begin
          state_d = w_start;
          chan_d  = 1'b1;
          cnt_d   = '0;
        end else if (w_lr_fall && chan_q) begin
          state_d = w_start;
          chan_d  = 1'b0;
          cnt_d   = '0;
        end
      end
      default: state_d = S_WAIT_LEFT;
    endcase
  end

  // A completing frame may reuse the output slot in the same cycle it is accepted.
  always_comb begin
    left_d  = left_q;
    right_d = right_q;
    valid_d = valid_q;
    ovr_set = 1'b0;
    if (frame_done) begin
      if (!valid_q || sample_ready_i) begin
        left_d  = stage_q;
        right_d = w_word;
        valid_d = 1'b1;
      end else begin
        ovr_set = 1'b1;
      end
    end else if (valid_q && sample_ready_i) begin
      valid_d = 1'b0;
    end
    ovr_d = ovr_set | (ovr_q & ~err_clear_i);
    fe_d  = fe_set  | (fe_q  & ~err_clear_i);
  end

  always_ff @(posedge mclk_i) begin
    if (!reset_n_i) begin
      state_q <= S_WAIT_LEFT;
      chan_q  <= 1'b0;
      cnt_q   <= '0;
      shift_q <= '0;
      stage_q <= '0;
      left_q  <= '0;
      right_q <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      chan_q  <= chan_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      stage_q <= stage_d;
      left_q  <= left_d;
      right_q <= right_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      fe_q    <= fe_d;
    end
  end

  assign left_sample_o   = left_q;
  assign right_sample_o  = right_q;
  assign sample_valid_o  = valid_q;
  assign overrun_o       = ovr_q;
  assign framing_error_o = fe_q;

endmodule

`default_nettype wire

// File: tb/tb_apu_i2s_receiver.sv
// ============================================================================
// tb_apu_i2s_receiver : scoreboard bench for the I2S capture block
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_apu_i2s_receiver;

  localparam int SW   = 24;
  localparam int SLOT = 32;
  localparam int HALF = 4;  // MCLK cycles per SCLK phase (SCLK = MCLK/8)

  logic          mclk = 1'b0;
  logic          reset_n, lrclk, sclk, din, ready, err_clear;
  logic [SW-1:0] left_s, right_s;
  logic          valid, overrun, ferr;

  int n_tests = 0, n_fail = 0, n_accepted = 0, n_expected = 0;
  logic [2*SW-1:0] exp_q[$];
  logic [2*SW-1:0] mon_e;

  always #5 mclk = ~mclk;

  apu_i2s_receiver #(.SAMPLE_WIDTH(SW), .SLOT_WIDTH(SLOT), .SYNC_STAGES(2)) dut (
    .mclk_i          (mclk),
    .reset_n_i       (reset_n),
    .lrclk_i         (lrclk),
    .sclk_i          (sclk),
    .din_i           (din),
    .left_sample_o   (left_s),
    .right_sample_o  (right_s),
    .sample_valid_o  (valid),
    .sample_ready_i  (ready),
    .overrun_o       (overrun),
    .framing_error_o (ferr),
    .err_clear_i     (err_clear)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge mclk);
      #1;
    end
  endtask

  // Bits first..first+n-1 of one slot; bit 0 is the I2S delay bit, 1..SW carry data MSB first.
  task automatic send_slot(input logic ch, input logic [SW-1:0] data, input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      lrclk = ch;
      sclk  = 1'b0;
      din   = (i >= 1 && i <= SW) ? data[SW-i] : 1'b0;
      tick(HALF);
      sclk  = 1'b1;
      tick(HALF);
    end
  endtask

  task automatic send_frame(input logic [SW-1:0] l, input logic [SW-1:0] r);
    send_slot(1'b0, l, 0, SLOT);
    send_slot(1'b1, r, 0, SLOT);
  endtask

  task automatic expect_frame(input logic [SW-1:0] l, input logic [SW-1:0] r);
    exp_q.push_back({l, r});
    n_expected++;
  endtask

  task automatic pulse_clear(input logic with_ready);
    err_clear = 1'b1;
    if (with_ready) ready = 1'b1;
    tick(1);
    err_clear = 1'b0;
    if (with_ready) ready = 1'b0;
    tick(2);
  endtask

  always @(negedge mclk) begin
    if (reset_n && valid && ready) begin
      n_accepted++;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_frame: got L=%h R=%h expected no frame", left_s, right_s);
      end else begin
        mon_e = exp_q.pop_front();
        check("frame_left",  {8'h0, left_s},  {8'h0, mon_e[2*SW-1:SW]});
        check("frame_right", {8'h0, right_s}, {8'h0, mon_e[SW-1:0]});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected run to complete");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; ready = 1'b0; err_clear = 1'b0;
    lrclk = 1'b0; sclk = 1'b0; din = 1'b0;
    tick(1);
    for (int i = 0; i < 4; i++) begin
      lrclk = 1'($urandom); sclk = 1'($urandom); din = 1'($urandom); ready = 1'($urandom);
      tick(1);
      check("reset_valid", {31'h0, valid}, 32'h0);
    end
    check("reset_left",    {8'h0, left_s},  32'h0);
    check("reset_right",   {8'h0, right_s}, 32'h0);
    check("reset_overrun", {31'h0, overrun}, 32'h0);
    check("reset_ferr",    {31'h0, ferr},    32'h0);

    lrclk = 1'b1; sclk = 1'b1; din = 1'b0; ready = 1'b1;
    reset_n = 1'b1;
    tick(4);
    send_slot(1'b1, 24'h0, 0, SLOT);

    expect_frame(24'hABCDEF, 24'h123456);
    send_frame(24'hABCDEF, 24'h123456);
    check("nominal_valid_done", {31'h0, valid},   32'h0);
    check("nominal_overrun",    {31'h0, overrun}, 32'h0);
    check("nominal_ferr",       {31'h0, ferr},    32'h0);

    ready = 1'b0;
    expect_frame(24'h000001, 24'h000002);
    send_frame(24'h000001, 24'h000002);
    check("bp_valid_held",   {31'h0, valid},   32'h1);
    check("bp_no_overrun_1", {31'h0, overrun}, 32'h0);
    send_frame(24'h000003, 24'h000004);
    check("bp_hold_left",  {8'h0, left_s},  32'h000001);
    check("bp_hold_right", {8'h0, right_s}, 32'h000002);
    check("bp_valid_2",    {31'h0, valid},   32'h1);
    check("bp_overrun",    {31'h0, overrun}, 32'h1);
    pulse_clear(1'b1);
    check("bp_overrun_cleared", {31'h0, overrun}, 32'h0);
    check("bp_valid_dropped",   {31'h0, valid},   32'h0);
    ready = 1'b1;
    expect_frame(24'h000005, 24'h000006);
    send_frame(24'h000005, 24'h000006);
    check("bp_after_overrun", {31'h0, overrun}, 32'h0);

    send_slot(1'b0, 24'hFFFFFF, 0, 10);
    send_slot(1'b1, 24'h777777, 0, SLOT);
    check("short_ferr",    {31'h0, ferr},    32'h1);
    check("short_overrun", {31'h0, overrun}, 32'h0);
    expect_frame(24'hA5A5A5, 24'h5A5A5A);
    send_frame(24'hA5A5A5, 24'h5A5A5A);
    check("short_ferr_sticky", {31'h0, ferr}, 32'h1);
    pulse_clear(1'b0);
    check("short_ferr_cleared", {31'h0, ferr}, 32'h0);

    reset_n = 1'b0;
    send_slot(1'b1, 24'h999999, 0, 6);
    reset_n = 1'b1;
    send_slot(1'b1, 24'h999999, 6, SLOT - 6);
    check("rstart_valid", {31'h0, valid}, 32'h0);
    check("rstart_ferr",  {31'h0, ferr},  32'h0);
    expect_frame(24'h13579B, 24'h2468AC);
    send_frame(24'h13579B, 24'h2468AC);

    send_slot(1'b0, 24'h111111, 0, SLOT);
    send_slot(1'b1, 24'h222222, 0, 12);
    reset_n = 1'b0;
    tick(3);
    reset_n = 1'b1;
    send_slot(1'b1, 24'h222222, 12, SLOT - 12);
    check("midrst_valid",   {31'h0, valid},   32'h0);
    check("midrst_left",    {8'h0, left_s},   32'h0);
    check("midrst_overrun", {31'h0, overrun}, 32'h0);
    check("midrst_ferr",    {31'h0, ferr},    32'h0);
    expect_frame(24'hFEDCBA, 24'h0F0F0F);
    send_frame(24'hFEDCBA, 24'h0F0F0F);
    tick(10);

    check("queue_empty",     exp_q.size(), 32'h0);
    check("frames_accepted", n_accepted,   n_expected);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
